pb_event_gen: RTL



---
 rtl/pb_event_pkg.sv | 6 +
 rtl/pb_edge_det.sv | 15 +
 rtl/pb_event_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pb_event_pkg.sv
// pb_event_pkg: shared state encoding and counter constants for pb_event_gen.
package pb_event_pkg;
  typedef enum logic [1:0] {LOCK, IDLE, HELD, LONG} state_t;
  localparam int CNT_W_DEF = 10;
  localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;
endpackage

// File: rtl/pb_edge_det.sv
// pb_edge_det: registers the button level and flags rising/falling edges; pb_q resets high.
module pb_edge_det (
  input  logic clk_1ms,
  input  logic rst,
  input  logic pb_i,
  output logic rise_o,
  output logic fall_o
);
  logic pb_q;
  always_ff @(posedge clk_1ms)
    if (rst) pb_q <= 1'b1;
    else pb_q <= pb_i;
  assign rise_o = pb_i & ~pb_q;
  assign fall_o = ~pb_i & pb_q;
endmodule

// File: rtl/pb_event_gen.sv
// pb_event_gen: push-button press/release/long/repeat event generator; define PB_DCLICK_EN for double-click.
module pb_event_gen
  import pb_event_pkg::*;
#(
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100,
  parameter int DCLICK_MS = 300,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk_1ms,
  input  logic             rst,
  input  logic             pbreg,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic             repeat_pulse,
  output logic             long_active,
  output logic [CNT_W-1:0] hold_ms,
  output logic             dclick_pulse
);
  localparam logic [CNT_W-1:0] SAT    = '1;
  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_MS);
  state_t state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d, rep_q, rep_d, hold_inc, rep_inc;
  logic press_q, press_d, rel_q, rel_d, long_q, long_d, rpt_q, rpt_d, la_q;
  logic rise, fall;
  pb_edge_det u_edge (
    .clk_1ms(clk_1ms),
    .rst    (rst),
    .pb_i   (pbreg),
    .rise_o (rise),
    .fall_o (fall)
  );
  assign hold_inc = hold_q + 1'b1;
  assign rep_inc  = rep_q + 1'b1;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    case (state_q)
      LOCK: state_d = pbreg ? LOCK : IDLE;
      IDLE: if (rise) begin
        press_d = 1'b1;
        hold_d  = CNT_W'(1);
        state_d = HELD;
      end
      HELD: if (fall) begin
        rel_d   = 1'b1;
        hold_d  = '0;
        state_d = IDLE;
      end else begin
        hold_d = hold_inc;
        if (hold_inc == LONG_C) begin
          long_d  = 1'b1;
          rep_d   = '0;
          state_d = LONG;
        end
      end
      LONG: if (fall) begin
        rel_d   = 1'b1;
        hold_d  = '0;
        state_d = IDLE;
      end else begin
        hold_d = (hold_q == SAT) ? SAT : hold_inc;
        rpt_d  = rep_inc == REP_C;
        rep_d  = (rep_inc == REP_C) ? '0 : rep_inc;
      end
      default: state_d = LOCK;
    endcase
  end
  always_ff @(posedge clk_1ms)
    if (rst) begin
      state_q <= LOCK;
      hold_q  <= '0;
      rep_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      la_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
      la_q    <= state_d == LONG;
    end
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = rpt_q;
  assign long_active   = la_q;
  assign hold_ms       = hold_q;
`ifdef PB_DCLICK_EN
  localparam logic [CNT_W-1:0] DCLK_C = CNT_W'(DCLICK_MS);
  logic [CNT_W-1:0] gap_q, gap_d;
  logic arm_q, arm_d, dck_q, dck_d;
  // gap_q counts idle edges after the release, so the rise edge itself is gap_q+1 cycles later
  always_comb begin
    gap_d = gap_q;
    arm_d = arm_q;
    dck_d = 1'b0;
    if (state_q == HELD && fall) begin
      gap_d = '0;
      arm_d = 1'b1;
    end else if (state_q == IDLE) begin
      gap_d = (gap_q == SAT) ? SAT : gap_q + 1'b1;
      dck_d = rise && arm_q && gap_q < DCLK_C;
      arm_d = arm_q && !rise && gap_q < DCLK_C;
    end else if (state_q == LONG && fall) arm_d = 1'b0;
  end
  always_ff @(posedge clk_1ms)
    if (rst) begin
      gap_q <= '0;
      arm_q <= 1'b0;
      dck_q <= 1'b0;
    end else begin
      gap_q <= gap_d;
      arm_q <= arm_d;
      dck_q <= dck_d;
    end
  assign dclick_pulse = dck_q;
`else
  assign dclick_pulse = 1'b0;
`endif
endmodule
